rptr_empty_lvl: RTL
===================

// Module: rptr_empty_lvl
// PURPOSE
//  Read-domain pointer/flag controller for the async FIFO; next generation of the read-pointer/empty block.
//  Keeps binary + Gray read pointers, registered empty, exact occupancy (rlevel), programmable almost-empty
//  with hysteresis, and a sticky underflow flag. Sits in the rclk domain between the wptr 2-flop
//  synchroniser (rq2_wptr) and the dual-port RAM read address.
// PARAMETERS
//  ADDR_LINES  8  RAM address width; depth = 2**ADDR_LINES; pointers are ADDR_LINES+1 bits
//  AE_HYST     2  hysteresis (entries) between ralmost_empty assert and deassert levels
// PORTS
//  rclk           in   1             read clock; the only clock in the block
//  rrst           in   1             reset, synchronous, active-low (sampled on posedge rclk)
//  rinc           in   1             read request; honoured only when rempty==0
//  rq2_wptr       in   ADDR_LINES+1  write pointer, Gray, already synchronised to rclk
//  ae_thresh      in   ADDR_LINES+1  almost-empty threshold (entries); quasi-static
//  clr_err        in   1             clears runderflow
//  raddr          out  ADDR_LINES    RAM read address = rbin[ADDR_LINES-1:0]
//  rptr           out  ADDR_LINES+1  Gray read pointer to the write-domain synchroniser
//  rempty         out  1             FIFO empty (registered)
//  ralmost_empty  out  1             occupancy at/below threshold, with hysteresis (registered)
//  rlevel         out  ADDR_LINES+1  entries readable, 0..2**ADDR_LINES (registered)
//  runderflow     out  1             sticky: rinc seen while rempty==1
// BEHAVIOUR
//  - Reset (rrst==0 at posedge): rbin=0, rptr=0, rempty=1, ralmost_empty=1, rlevel=0, runderflow=0,
//    state=RD_EMPTY. Mid-operation reset wins over every other input that cycle.
//  - rbinnext = rbin + (rinc & ~rempty), modulo 2**(ADDR_LINES+1); rgraynext = (rbinnext>>1) ^ rbinnext.
//    Both register into rbin/rptr each edge. Pointer wrap from all-ones to 0 is normal; MSB toggles.
//  - rq2_wbin = gray-to-binary(rq2_wptr), combinational.
//    lvl_next = rq2_wbin - rbinnext, modulo 2**(ADDR_LINES+1). No subtraction overflow detection.
//  - rempty <= (rgraynext == rq2_wptr). rlevel <= lvl_next. Latency: a pop is reflected in rlevel,
//    rempty and rptr on the same edge that advances raddr (one cycle after rinc is sampled).
//  - Underflow: rinc & rempty -> pointer holds, runderflow <= 1 next edge. Sticky until clr_err.
//    clr_err and a new underflow in the same cycle: set wins.
//  - Level FSM (state type rd_lvl_t), evaluated on lvl_next:
//      RD_EMPTY : lvl_next==0 stay; else if lvl_next<=ae_thresh -> RD_LOW; else -> RD_OK
//      RD_LOW   : lvl_next==0 -> RD_EMPTY; lvl_next > ae_thresh+AE_HYST -> RD_OK; else stay
//      RD_OK    : lvl_next==0 -> RD_EMPTY; lvl_next <= ae_thresh -> RD_LOW; else stay
//    ralmost_empty = (state != RD_OK), registered with the state.
//    ae_thresh+AE_HYST is computed ADDR_LINES+2 bits wide (no wrap).
//    ae_thresh >= 2**ADDR_LINES: ralmost_empty stays asserted permanently.
//    ae_thresh==0: ralmost_empty equals rempty.
//  - Simultaneous write arrival and pop: lvl_next accounts for both; rlevel is unchanged when they net to zero.
//  - Flags are pessimistic: synchroniser delay only makes rlevel low and rempty early, never late.
// STRUCTURE
//  - fifo_pkg: typedef enum logic [1:0] {RD_EMPTY, RD_LOW, RD_OK} rd_lvl_t; function bin2gray.
//    The write-side block shares both.
//  - Sub-module gray2bin #(.W(ADDR_LINES+1)): XOR-prefix decoder. The write-side level block reuses it.
//  - Everything else is flat: pointer regs, level/flag regs, FSM, underflow flag.
// TESTING (ADDR_LINES=4, AE_HYST=2, ae_thresh=3 unless stated)
//  1 Reset: rrst=0 for 2 clocks with rinc=1 -> rempty=1, ralmost_empty=1, rlevel=0, rptr=0, runderflow=0.
//  2 Drive rq2_wptr Gray of 6, no rinc -> next edge: rempty=0, rlevel=6, ralmost_empty=0.
//    Then pop 3 -> rlevel 3, ralmost_empty=1. Then wptr to Gray 8 (lvl 5) -> stays 1.
//    Then wptr to Gray 9 (lvl 6) -> 0.
//  3 Underflow: empty, rinc=1 one cycle -> raddr unchanged, runderflow=1.
//    clr_err=1 together with another rinc -> stays 1. clr_err alone -> 0.
//  4 Wrap: preload rbin=30 via 30 pops, wptr=Gray(2)=3 -> rlevel=4. Two pops -> rbin=0, rptr MSB toggled.
//    Two more pops -> rempty=1.
//  5 Full: rq2_wptr=Gray(16), rbin=0 -> rlevel=16, rempty=0. Simultaneous pop + write -> rlevel stays 16.
//  6 Mid-op reset: rlevel=10, rrst=0 for one edge -> all outputs at reset values that edge.
//    ae_thresh=20 -> ralmost_empty=1 at any level.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO read and write pointer blocks.
package fifo_pkg;

  typedef enum logic [1:0] {
    RD_EMPTY = 2'd0,
    RD_LOW   = 2'd1,
    RD_OK    = 2'd2
  } rd_lvl_t;

  // Callers pass a zero-extended pointer and keep only the bits they need.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end

endmodule

// File: rtl/rptr_empty_lvl.sv
// Read-domain pointer and flag controller: binary/Gray read pointers, registered empty,
// exact occupancy, almost-empty with hysteresis and a sticky underflow flag.
module rptr_empty_lvl
  import fifo_pkg::*;
#(
  parameter int ADDR_LINES = 8,
  parameter int AE_HYST    = 2
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rinc,
  input  logic [ADDR_LINES:0]   rq2_wptr,
  input  logic [ADDR_LINES:0]   ae_thresh,
  input  logic                  clr_err,
  output logic [ADDR_LINES-1:0] raddr,
  output logic [ADDR_LINES:0]   rptr,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_LINES:0]   rlevel,
  output logic                  runderflow
);

  localparam int PW = ADDR_LINES + 1;

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] rlevel_q, rlevel_d;
  logic          rempty_q, rempty_d;
  logic          rae_q, rae_d;
  logic          runder_q, runder_d;
  rd_lvl_t       state_q, state_d;

  logic [PW-1:0] rq2_wbin;
  logic          pop;
  logic [PW:0]   thr_hi;

  gray2bin #(.W(PW)) u_wptr_dec (
    .gray_i (rq2_wptr),
    .bin_o  (rq2_wbin)
  );

  assign pop    = rinc & ~rempty_q;
  assign thr_hi = {1'b0, ae_thresh} + (PW+1)'(AE_HYST);

  always_comb begin
    rbin_d   = rbin_q + PW'(pop);
    rptr_d   = PW'(bin2gray(32'(rbin_d)));
    rempty_d = (rptr_d == rq2_wptr);
    rlevel_d = rq2_wbin - rbin_d;
    runder_d = runder_q;
    if (clr_err)
      runder_d = 1'b0;
    // A pop attempt against an empty FIFO outranks a same-cycle clear.
    if (rinc && rempty_q)
      runder_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_EMPTY: begin
        if (rlevel_d == '0)              state_d = RD_EMPTY;
        else if (rlevel_d <= ae_thresh)  state_d = RD_LOW;
        else                             state_d = RD_OK;
      end
      RD_LOW: begin
        if (rlevel_d == '0)                  state_d = RD_EMPTY;
        else if ({1'b0, rlevel_d} > thr_hi)  state_d = RD_OK;
      end
      RD_OK: begin
        if (rlevel_d == '0)              state_d = RD_EMPTY;
        else if (rlevel_d <= ae_thresh)  state_d = RD_LOW;
      end
      default: state_d = RD_EMPTY;
    endcase
    rae_d = (state_d != RD_OK);
  end

  always_ff @(posedge rclk) begin
    if (!rrst) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rlevel_q <= '0;
      rempty_q <= 1'b1;
      rae_q    <= 1'b1;
      runder_q <= 1'b0;
      state_q  <= RD_EMPTY;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rlevel_q <= rlevel_d;
      rempty_q <= rempty_d;
      rae_q    <= rae_d;
      runder_q <= runder_d;
      state_q  <= state_d;
    end
  end

  assign raddr         = rbin_q[ADDR_LINES-1:0];
  assign rptr          = rptr_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = rae_q;
  assign rlevel        = rlevel_q;
  assign runderflow    = runder_q;

endmodule
